// File: rtl/master_game_defs_pkg.sv
// Shared game-flow definitions: MASTER_STATE width and state encodings.
// The VGA, snake-control and score blocks import this package so they all
// decode the same values.
package master_game_defs;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_WIN   = 3'd2,
    ST_LOSE  = 3'd3,
    ST_PAUSE = 3'd4
  } master_state_t;

endpackage

// File: rtl/master_game_sm_edge_detect.sv
// Rising-edge detector for a vector of synchronised, debounced inputs.
// The history register resets to RST_VAL (all-ones by default), so an input
// that is already high when reset releases does not register as a rise.
module master_game_sm_edge_detect #(
  parameter int unsigned W = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] sig,
  output logic [W-1:0] rise
);

  logic [W-1:0] sig_q;

  // Sample the input every cycle to remember its previous value.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sig_q <= RST_VAL;
    end else begin
      sig_q <= sig;
    end
  end

  // A rise is a bit that is high now but was low on the previous cycle.
  always_comb begin
    rise = sig & ~sig_q;
  end

endmodule

// File: rtl/master_game_sm.sv
// Top-level game-flow controller for the snake game. Decides when a round
// starts, pauses, is won or lost, keeps the round score, and returns to IDLE
// automatically after a fixed hold time in WIN or LOSE. All outputs are
// registered; MASTER_STATE is the live FSM state for downstream blocks.
module master_game_sm
  import master_game_defs::*;
#(
  parameter int unsigned NUM_BTNS        = 4,
  parameter int unsigned SCORE_W         = 8,
  parameter int unsigned WIN_SCORE       = 10,
  parameter int unsigned END_HOLD_CYCLES = 100
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_BTNS-1:0] BTN,
  input  logic                BTN_PAUSE,
  input  logic                SCORE_PULSE,
  input  logic                COLLISION,
  output logic [STATE_W-1:0]  MASTER_STATE,
  output logic [SCORE_W-1:0]  SCORE,
  output logic                STATE_CHANGE
);

  localparam int unsigned HOLD_W = $clog2(END_HOLD_CYCLES + 1);
  localparam logic [SCORE_W-1:0] WIN_VAL      = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] WIN_LAST     = SCORE_W'(WIN_SCORE - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(END_HOLD_CYCLES - 1);

  master_state_t       curr_state, next_state;
  logic [SCORE_W-1:0]  score, next_score;
  logic [HOLD_W-1:0]   hold_cnt, next_hold;
  logic                state_change;
  logic [NUM_BTNS-1:0] btn_rise;
  logic                pause_rise;

  master_game_sm_edge_detect #(
    .W      (NUM_BTNS),
    .RST_VAL({NUM_BTNS{1'b1}})
  ) u_btn_edge (
    .CLK  (CLK),
    .RESET(RESET),
    .sig  (BTN),
    .rise (btn_rise)
  );

  master_game_sm_edge_detect #(
    .W      (1),
    .RST_VAL(1'b1)
  ) u_pause_edge (
    .CLK  (CLK),
    .RESET(RESET),
    .sig  (BTN_PAUSE),
    .rise (pause_rise)
  );

  // Next-state, score and hold-counter logic; every path holds by default.
  always_comb begin
    next_state = curr_state;
    next_score = score;
    next_hold  = '0;
    case (curr_state)
      ST_IDLE: begin
        if (|btn_rise) begin
          next_state = ST_PLAY;
          next_score = '0;
        end
      end
      ST_PLAY: begin
        // Collision wins over a same-cycle score pulse; a score pulse wins
        // over a same-cycle pause press (the pause must be pressed again).
        if (COLLISION) begin
          next_state = ST_LOSE;
        end else if (SCORE_PULSE) begin
          if (score == WIN_LAST) begin
            next_score = WIN_VAL;
            next_state = ST_WIN;
          end else begin
            next_score = score + SCORE_W'(1);
          end
        end else if (pause_rise) begin
          next_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_rise) begin
          next_state = ST_PLAY;
        end
      end
      ST_WIN, ST_LOSE: begin
        // Score holds its final value; counter restarts from 0 on exit.
        if (hold_cnt == HOLD_LAST) begin
          next_state = ST_IDLE;
        end else begin
          next_hold = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        // Unused encodings recover to a clean IDLE.
        next_state = ST_IDLE;
        next_score = '0;
      end
    endcase
  end

  // State, score, hold counter and change pulse registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      curr_state   <= ST_IDLE;
      score        <= '0;
      hold_cnt     <= '0;
      state_change <= 1'b0;
    end else begin
      curr_state   <= next_state;
      score        <= next_score;
      hold_cnt     <= next_hold;
      state_change <= (next_state != curr_state);
    end
  end

  // Outputs are the registers themselves.
  always_comb begin
    MASTER_STATE = curr_state;
    SCORE        = score;
    STATE_CHANGE = state_change;
  end

endmodule
